// File: rtl/bcd_rtc_core.sv
// bcd_rtc_core: BCD real-time clock with a prescaler, 12 h / 24 h modes,
// a validated time-load port, run/pause control and a one-cycle tick strobe.
// Optional alarm comparator is compiled in when RTC_ALARM_EN is defined.
module bcd_rtc_core #(
  parameter int TICK_DIV = 50000000,
  parameter int HOUR_24  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] load_hour,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       load_pm,
`ifdef RTC_ALARM_EN
  input  logic       alarm_set,
  input  logic [7:0] alarm_hour,
  input  logic [7:0] alarm_min,
  input  logic       alarm_pm,
  input  logic       alarm_on,
  output logic       alarm,
`endif
  output logic [7:0] hour,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       pm,
  output logic       tick,
  output logic       load_err
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    HOUR_RST   = (HOUR_24 != 0) ? 8'h00 : 8'h12;

  function automatic logic bcd_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic logic min_sec_ok(input logic [7:0] b);
    return bcd_ok(b) && (b <= 8'h59);
  endfunction

  // Valid BCD bytes order the same way as their decimal values.
  function automatic logic hour_ok(input logic [7:0] h);
    if (HOUR_24 != 0) return bcd_ok(h) && (h <= 8'h23);
    return bcd_ok(h) && (h >= 8'h01) && (h <= 8'h12);
  endfunction

  // Returns {carry, next} for a 00..59 BCD field.
  function automatic logic [8:0] inc_60(input logic [7:0] b);
    if (b == 8'h59) return {1'b1, 8'h00};
    if (b[3:0] == 4'd9) return {1'b0, b[7:4] + 4'd1, 4'd0};
    return {1'b0, b[7:4], b[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_hour(input logic [7:0] h);
    if ((HOUR_24 != 0) && (h == 8'h23)) return 8'h00;
    if ((HOUR_24 == 0) && (h == 8'h12)) return 8'h01;
    if (h[3:0] == 4'd9) return {h[7:4] + 4'd1, 4'd0};
    return {h[7:4], h[3:0] + 4'd1};
  endfunction

  logic [PW-1:0] presc_p0;
  logic          wrap_p0;
  logic          load_ok_p0;
  logic          vld_p0;
  logic          alarm_err_p0;
  logic          c_sec_p0;
  logic          c_min_p0;
  logic [7:0]    nxt_sec_p0;
  logic [7:0]    nxt_min_p0;
  logic [7:0]    nxt_hour_p0;
  logic          nxt_pm_p0;

  // Stage p0: prescaler wrap detect, load validation and next-time computation.
  assign wrap_p0    = run && (presc_p0 == PRESC_LAST);
  assign load_ok_p0 = load && hour_ok(load_hour) && min_sec_ok(load_min) && min_sec_ok(load_sec);
  assign vld_p0     = wrap_p0 && !load_ok_p0;

  always_comb begin
    c_sec_p0    = 1'b0;
    c_min_p0    = 1'b0;
    nxt_sec_p0  = sec;
    nxt_min_p0  = min;
    nxt_hour_p0 = hour;
    nxt_pm_p0   = pm;
    {c_sec_p0, nxt_sec_p0} = inc_60(sec);
    if (c_sec_p0) begin
      {c_min_p0, nxt_min_p0} = inc_60(min);
      if (c_min_p0) begin
        nxt_hour_p0 = inc_hour(hour);
        if ((HOUR_24 == 0) && (hour == 8'h11)) nxt_pm_p0 = ~pm;
      end
    end
  end

  // Stage p1: registered prescaler, time fields and strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_p0 <= '0;
      sec      <= 8'h00;
      min      <= 8'h00;
      hour     <= HOUR_RST;
      pm       <= 1'b0;
      tick     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick     <= vld_p0;
      load_err <= (load && !load_ok_p0) || alarm_err_p0;
      if (load_ok_p0) begin
        presc_p0 <= '0;
        sec      <= load_sec;
        min      <= load_min;
        hour     <= load_hour;
        pm       <= (HOUR_24 == 0) ? load_pm : 1'b0;
      end else if (run) begin
        presc_p0 <= wrap_p0 ? '0 : presc_p0 + PW'(1);
        if (wrap_p0) begin
          sec  <= nxt_sec_p0;
          min  <= nxt_min_p0;
          hour <= nxt_hour_p0;
          pm   <= nxt_pm_p0;
        end
      end
    end
  end

`ifdef RTC_ALARM_EN
  logic [7:0] al_hour;
  logic [7:0] al_min;
  logic       al_pm;
  logic       al_ok_p0;
  logic       al_match_p0;

  assign al_ok_p0     = alarm_set && hour_ok(alarm_hour) && min_sec_ok(alarm_min);
  assign alarm_err_p0 = alarm_set && !al_ok_p0;
  assign al_match_p0  = (nxt_sec_p0 == 8'h00) && (nxt_min_p0 == al_min) &&
                        (nxt_hour_p0 == al_hour) && ((HOUR_24 != 0) || (nxt_pm_p0 == al_pm));

  // Stage p1: stored alarm time and sticky alarm flag, raised only by a tick advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      al_hour <= HOUR_RST;
      al_min  <= 8'h00;
      al_pm   <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      if (al_ok_p0) begin
        al_hour <= alarm_hour;
        al_min  <= alarm_min;
        al_pm   <= (HOUR_24 == 0) ? alarm_pm : 1'b0;
      end
      if (!alarm_on) alarm <= 1'b0;
      else if (vld_p0 && al_match_p0) alarm <= 1'b1;
    end
  end
`else
  assign alarm_err_p0 = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_rtc_core.sv
// Directed bench for bcd_rtc_core: one 12 h instance and one 24 h instance,
// both with TICK_DIV=4. Alarm checks are compiled when RTC_ALARM_EN is defined.
module tb_bcd_rtc_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       run, load, lp;
  logic [7:0] lh, lm, ls;
  logic [7:0] hour, min, sec;
  logic       pm, tick, load_err;

  logic       run24, load24, lp24;
  logic [7:0] lh24, lm24, ls24;
  logic [7:0] hour24, min24, sec24;
  logic       pm24, tick24, load_err24;

  int vectors     = 0;
  int miscompares = 0;
  int nticks;

`ifdef RTC_ALARM_EN
  logic       al_set, al_pm, al_on, alarm;
  logic [7:0] al_hour, al_min;
  logic       alarm24;
  logic       zero1 = 1'b0;
  logic [7:0] zero8 = 8'h00;
`endif

  always #5 clk = ~clk;

  bcd_rtc_core #(.TICK_DIV(4), .HOUR_24(0)) dut12 (
    .clk(clk), .reset(reset), .run(run), .load(load),
    .load_hour(lh), .load_min(lm), .load_sec(ls), .load_pm(lp),
`ifdef RTC_ALARM_EN
    .alarm_set(al_set), .alarm_hour(al_hour), .alarm_min(al_min),
    .alarm_pm(al_pm), .alarm_on(al_on), .alarm(alarm),
`endif
    .hour(hour), .min(min), .sec(sec), .pm(pm), .tick(tick), .load_err(load_err)
  );

  bcd_rtc_core #(.TICK_DIV(4), .HOUR_24(1)) dut24 (
    .clk(clk), .reset(reset), .run(run24), .load(load24),
    .load_hour(lh24), .load_min(lm24), .load_sec(ls24), .load_pm(lp24),
`ifdef RTC_ALARM_EN
    .alarm_set(zero1), .alarm_hour(zero8), .alarm_min(zero8),
    .alarm_pm(zero1), .alarm_on(zero1), .alarm(alarm24),
`endif
    .hour(hour24), .min(min24), .sec(sec24), .pm(pm24), .tick(tick24), .load_err(load_err24)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_t12(input string tag, input logic [7:0] h, input logic [7:0] m,
                         input logic [7:0] s, input logic p);
    chk8({tag, ".hour"}, hour, h);
    chk8({tag, ".min"}, min, m);
    chk8({tag, ".sec"}, sec, s);
    chk1({tag, ".pm"}, pm, p);
  endtask

  task automatic chk_t24(input string tag, input logic [7:0] h, input logic [7:0] m,
                         input logic [7:0] s);
    chk8({tag, ".hour24"}, hour24, h);
    chk8({tag, ".min24"}, min24, m);
    chk8({tag, ".sec24"}, sec24, s);
    chk1({tag, ".pm24"}, pm24, 1'b0);
  endtask

  // Present a load for one cycle on the 12 h instance.
  task automatic load12(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                        input logic p);
    lh = h; lm = m; ls = s; lp = p; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic load_24(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                         input logic p);
    lh24 = h; lm24 = m; ls24 = s; lp24 = p; load24 = 1'b1;
    step(1);
    load24 = 1'b0;
  endtask

  // Rejected load on the frozen 12 h instance: one load_err pulse, time unchanged.
  task automatic bad12(input string tag, input logic [7:0] h, input logic [7:0] m,
                       input logic [7:0] s);
    load12(h, m, s, 1'b1);
    chk1({tag, ".err"}, load_err, 1'b1);
    chk_t12(tag, 8'h01, 8'h00, 8'h00, 1'b0);
    step(1);
    chk1({tag, ".err_clr"}, load_err, 1'b0);
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; load = 1'b0; lh = 8'h00; lm = 8'h00; ls = 8'h00; lp = 1'b0;
    run24 = 1'b0; load24 = 1'b0; lh24 = 8'h00; lm24 = 8'h00; ls24 = 8'h00; lp24 = 1'b0;
`ifdef RTC_ALARM_EN
    al_set = 1'b0; al_hour = 8'h00; al_min = 8'h00; al_pm = 1'b0; al_on = 1'b0;
`endif
    step(2);

    // Reset values
    chk_t12("rst", 8'h12, 8'h00, 8'h00, 1'b0);
    chk1("rst.tick", tick, 1'b0);
    chk1("rst.err", load_err, 1'b0);
    chk_t24("rst24", 8'h00, 8'h00, 8'h00);

    // Free run: a tick every 4 cycles
    reset = 1'b1; run = 1'b1;
    step(3);
    chk1("run.pre_tick", tick, 1'b0);
    chk8("run.pre_sec", sec, 8'h00);
    step(1);
    chk1("run.tick1", tick, 1'b1);
    chk8("run.sec1", sec, 8'h01);
    step(1);
    chk1("run.tick_pulse", tick, 1'b0);
    step(3);
    chk1("run.tick2", tick, 1'b1);
    step(4);
    chk1("run.tick3", tick, 1'b1);
    chk_t12("run3", 8'h12, 8'h00, 8'h03, 1'b0);

    // 11:59:59 AM -> 12:00:00 PM
    load12(8'h11, 8'h59, 8'h59, 1'b0);
    chk_t12("ld_am", 8'h11, 8'h59, 8'h59, 1'b0);
    chk1("ld_am.tick", tick, 1'b0);
    step(4);
    chk1("am2pm.tick", tick, 1'b1);
    chk_t12("am2pm", 8'h12, 8'h00, 8'h00, 1'b1);

    // 11:59:58 PM -> 12:00:00 AM, then one hour on to 01:00:00 AM
    load12(8'h11, 8'h59, 8'h58, 1'b1);
    step(4);
    chk1("pm.tick1", tick, 1'b1);
    chk_t12("pm1", 8'h11, 8'h59, 8'h59, 1'b1);
    step(4);
    chk_t12("pm2am", 8'h12, 8'h00, 8'h00, 1'b0);
    step(14400);
    chk1("hour.tick", tick, 1'b1);
    chk_t12("hour", 8'h01, 8'h00, 8'h00, 1'b0);

    // Rejected loads while frozen
    run = 1'b0;
    bad12("bad_sec", 8'h01, 8'h00, 8'h1A);
    bad12("bad_min", 8'h01, 8'h60, 8'h00);
    bad12("bad_h13", 8'h13, 8'h00, 8'h00);
    bad12("bad_h00", 8'h00, 8'h30, 8'h00);

    // Rejected load does not clear the prescaler
    run = 1'b1;
    load12(8'h01, 8'h00, 8'h1A, 1'b0);
    chk1("rej.err", load_err, 1'b1);
    chk1("rej.tick0", tick, 1'b0);
    step(2);
    chk1("rej.tick_early", tick, 1'b0);
    step(1);
    chk1("rej.tick", tick, 1'b1);
    chk_t12("rej", 8'h01, 8'h00, 8'h01, 1'b0);

    // Load on the wrap cycle wins; no tick
    step(3);
    load12(8'h05, 8'h06, 8'h07, 1'b1);
    chk_t12("wrapld", 8'h05, 8'h06, 8'h07, 1'b1);
    chk1("wrapld.tick", tick, 1'b0);
    step(3);
    chk1("wrapld.tick_early", tick, 1'b0);
    step(1);
    chk1("wrapld.tick_next", tick, 1'b1);
    chk8("wrapld.sec", sec, 8'h08);

    // run=0 freezes time for 20 cycles
    run = 1'b0;
    nticks = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (tick) nticks++;
    end
    chk8("freeze.ticks", 8'(nticks), 8'd0);
    chk_t12("freeze", 8'h05, 8'h06, 8'h08, 1'b1);

    // Reset mid-count with a pending load
    run = 1'b1;
    step(2);
    lh = 8'h03; lm = 8'h03; ls = 8'h03; lp = 1'b1; load = 1'b1;
    reset = 1'b0;
    #1;
    chk_t12("amid", 8'h12, 8'h00, 8'h00, 1'b0);
    chk1("amid.tick", tick, 1'b0);
    chk8("amid.hour24", hour24, 8'h00);
    step(1);
    reset = 1'b1; load = 1'b0;
    step(1);
    chk_t12("amid_rel", 8'h12, 8'h00, 8'h00, 1'b0);

    // 24 h mode rollovers
    run24 = 1'b1;
    load_24(8'h23, 8'h59, 8'h59, 1'b1);
    chk_t24("l2359", 8'h23, 8'h59, 8'h59);
    step(4);
    chk1("r2359.tick", tick24, 1'b1);
    chk_t24("r2359", 8'h00, 8'h00, 8'h00);
    load_24(8'h09, 8'h59, 8'h59, 1'b0);
    step(4);
    chk_t24("r0959", 8'h10, 8'h00, 8'h00);
    load_24(8'h19, 8'h59, 8'h59, 1'b0);
    step(4);
    chk_t24("r1959", 8'h20, 8'h00, 8'h00);
    run24 = 1'b0;
    load_24(8'h24, 8'h00, 8'h00, 1'b0);
    chk1("bad24.err", load_err24, 1'b1);
    chk_t24("bad24", 8'h20, 8'h00, 8'h00);

`ifdef RTC_ALARM_EN
    // Alarm 07:30 AM; load 07:29:59 AM; one tick raises alarm
    run = 1'b1;
    al_set = 1'b1; al_hour = 8'h07; al_min = 8'h30; al_pm = 1'b0; al_on = 1'b1;
    load12(8'h07, 8'h29, 8'h59, 1'b0);
    al_set = 1'b0;
    chk1("al.pre", alarm, 1'b0);
    step(4);
    chk_t12("al", 8'h07, 8'h30, 8'h00, 1'b0);
    chk1("al.fire", alarm, 1'b1);
    step(4);
    chk1("al.hold", alarm, 1'b1);
    al_on = 1'b0;
    step(1);
    chk1("al.off", alarm, 1'b0);
    al_on = 1'b1;
    load12(8'h07, 8'h30, 8'h00, 1'b0);
    chk1("al.loadmatch", alarm, 1'b0);
    al_set = 1'b1; al_hour = 8'h13;
    step(1);
    al_set = 1'b0;
    chk1("al.bad", load_err, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
